// File: rtl/eth_vlan_parser.sv
// Ethernet L2 header parser with 802.1Q / 802.1ad VLAN tag extraction.
// The byte stream is forwarded untouched with one cycle of latency. The
// destination MAC, source MAC, up to MAX_VLAN VLAN IDs, the inner EtherType
// and the L3 header offset are extracted as the bytes go past.
//
// state  | meaning
// S_MAC  | collecting dst MAC (bytes 0-5) then src MAC (bytes 6-11)
// S_TYPE | collecting a 2-byte EtherType / TPID
// S_TAG  | collecting a 2-byte TCI; its low 12 bits are the VLAN ID
// S_DONE | header complete, skipping payload until last
module eth_vlan_parser #(
    parameter int  DATA_WIDTH = 64,
    parameter int  MAX_VLAN   = 2,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int IW         = $clog2(DATA_WIDTH / 8 + 1),
    localparam int VW         = (MAX_VLAN > 0) ? MAX_VLAN : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tdata_in,
    input  logic [IW-1:0]         idx_in,
    input  logic                  data_valid_in,
    input  logic                  last_flag_in,
    output logic [DATA_WIDTH-1:0] tdata_out,
    output logic [IW-1:0]         idx_out,
    output logic                  data_valid_out,
    output logic                  last_flag_out,
    output logic                  hdr_valid,
    output logic                  hdr_error,
    output logic [47:0]           dst_mac,
    output logic [47:0]           src_mac,
    output logic [15:0]           eth_type,
    output logic [1:0]            vlan_count,
    output logic [12*VW-1:0]      vlan_id,
    output logic [4:0]            l3_offset
);

    typedef enum logic [1:0] {S_MAC, S_TYPE, S_TAG, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        vc_q, vc_d;
    logic [15:0]       sh_q, sh_d;
    logic [47:0]       dst_q, dst_d;
    logic [47:0]       src_q, src_d;
    logic [15:0]       type_q, type_d;
    logic [12*VW-1:0]  vid_q, vid_d;
    logic [4:0]        l3_q, l3_d;
    logic              hv_q, hv_d;
    logic              he_q, he_d;
    logic [7:0]        byte_v;

    logic [DATA_WIDTH-1:0] data_q;
    logic [IW-1:0]         idx_q;
    logic                  dv_q;
    logic                  last_q;

    // Walk every valid byte of the beat through the FSM in wire order.
    // vlan_count is cleared at a frame's first byte rather than at last so
    // the finished frame's fields stay stable while last_flag_out is shown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vc_d    = vc_q;
        sh_d    = sh_q;
        dst_d   = dst_q;
        src_d   = src_q;
        type_d  = type_q;
        vid_d   = vid_q;
        l3_d    = l3_q;
        he_d    = 1'b0;
        byte_v  = 8'h00;

        if (data_valid_in) begin
            for (int i = 0; i < NB; i++) begin
                if (i < int'(idx_in)) begin
                    byte_v = tdata_in[i*8 +: 8];
                    if (state_d == S_MAC && cnt_d == 4'd0) begin
                        vc_d = 2'd0;
                    end
                    case (state_d)
                        S_MAC: begin
                            if (cnt_d < 4'd6) begin
                                dst_d = {dst_d[39:0], byte_v};
                            end else begin
                                src_d = {src_d[39:0], byte_v};
                            end
                            if (cnt_d == 4'd11) begin
                                state_d = S_TYPE;
                                cnt_d   = 4'd0;
                            end else begin
                                cnt_d = cnt_d + 4'd1;
                            end
                        end
                        S_TYPE: begin
                            sh_d = {sh_d[7:0], byte_v};
                            if (cnt_d == 4'd1) begin
                                cnt_d = 4'd0;
                                if ((sh_d == 16'h8100 || sh_d == 16'h88A8) &&
                                    int'(vc_d) < MAX_VLAN) begin
                                    state_d = S_TAG;
                                end else begin
                                    type_d  = sh_d;
                                    l3_d    = 5'd14 + {1'b0, vc_d, 2'b00};
                                    state_d = S_DONE;
                                end
                            end else begin
                                cnt_d = cnt_d + 4'd1;
                            end
                        end
                        S_TAG: begin
                            sh_d = {sh_d[7:0], byte_v};
                            if (cnt_d == 4'd1) begin
                                for (int k = 0; k < VW; k++) begin
                                    if (k == int'(vc_d)) begin
                                        vid_d[k*12 +: 12] = sh_d[11:0];
                                    end
                                end
                                vc_d    = vc_d + 2'd1;
                                cnt_d   = 4'd0;
                                state_d = S_TYPE;
                            end else begin
                                cnt_d = cnt_d + 4'd1;
                            end
                        end
                        S_DONE: begin
                            if (cnt_d != 4'hF) begin
                                cnt_d = cnt_d + 4'd1;
                            end
                        end
                        default: state_d = S_MAC;
                    endcase
                end
            end
        end

        // hdr_valid follows the state reached after this beat's bytes; after
        // the last beat the FSM is back in S_MAC so it drops the cycle after.
        hv_d = (state_d == S_DONE);

        if (data_valid_in && last_flag_in) begin
            he_d    = (state_d != S_DONE);
            state_d = S_MAC;
            cnt_d   = 4'd0;
        end
    end

    // Parser state and extracted header fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MAC;
            cnt_q   <= 4'd0;
            vc_q    <= 2'd0;
            sh_q    <= 16'h0000;
            dst_q   <= 48'h0;
            src_q   <= 48'h0;
            type_q  <= 16'h0000;
            vid_q   <= '0;
            l3_q    <= 5'd0;
            hv_q    <= 1'b0;
            he_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vc_q    <= vc_d;
            sh_q    <= sh_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            type_q  <= type_d;
            vid_q   <= vid_d;
            l3_q    <= l3_d;
            hv_q    <= hv_d;
            he_q    <= he_d;
        end
    end

    // One-cycle stream pass-through, never modified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
            dv_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            data_q <= tdata_in;
            idx_q  <= idx_in;
            dv_q   <= data_valid_in;
            last_q <= last_flag_in & data_valid_in;
        end
    end

    assign tdata_out      = data_q;
    assign idx_out        = idx_q;
    assign data_valid_out = dv_q;
    assign last_flag_out  = last_q;
    assign hdr_valid      = hv_q;
    assign hdr_error      = he_q;
    assign dst_mac        = dst_q;
    assign src_mac        = src_q;
    assign eth_type       = type_q;
    assign vlan_count     = vc_q;
    assign vlan_id        = vid_q;
    assign l3_offset      = l3_q;

endmodule
